// File: rtl/spdif_bmc_tx.sv
// S/PDIF transmitter: valid/ready payload intake, A/B subframe and 192-frame block sequencing, BMC line.
// Optional macro SPDIF_TX_ENABLE_EN adds i_ena; while low the line idles at 0 and sequencing restarts at a block start.
module spdif_bmc_tx #(
    parameter int HALF_BIT_CLKS = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
`ifdef SPDIF_TX_ENABLE_EN
    input  logic        i_ena,
`endif
    input  logic [23:0] i_data,
    input  logic        i_v,
    input  logic        i_u,
    input  logic        i_c,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_chan_b,
    output logic        o_spdif,
    output logic        o_block_start,
    output logic        o_underrun
);
    localparam int CNT_W = $clog2(HALF_BIT_CLKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BIT_CLKS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]  PRE_B = 8'b1110_1000;
    localparam logic [7:0]  PRE_M = 8'b1110_0010;
    localparam logic [7:0]  PRE_W = 8'b1110_0100;
    localparam logic [26:0] UNDERRUN_PL = 27'h100_0000;

    function automatic logic even_parity(input logic [26:0] pl);
        return ^pl;
    endfunction

    // Word indexed by slot: slots 0-3 unused (preamble), 4-30 payload, 31 parity.
    function automatic logic [31:0] build_word(input logic [26:0] pl);
        return {even_parity(pl), pl, 4'b0000};
    endfunction

    logic [CNT_W-1:0] clk_cnt_r, clk_cnt_nx;
    logic [5:0]       cell_r, cell_nx;
    logic             sub_r, sub_nx;
    logic [7:0]       frame_r, frame_nx;
    logic             ready_r, ready_nx;
    logic [26:0]      hold_r;
    logic [31:0]      sreg_r;
    logic             uflag_r;
    logic             lvl_r;
    logic             o_spdif_r, o_chan_b_r, o_block_start_r, o_underrun_r;
    logic             run_s, cell_end_s, load_s, load_nx_s, accept_s, start_s;
    logic             chan_nx, line_nx;
    logic [7:0]       pre_s;

`ifdef SPDIF_TX_ENABLE_EN
    assign run_s = i_ena;
`else
    assign run_s = 1'b1;
`endif

    assign cell_end_s = (clk_cnt_r == CNT_LAST);
    assign load_s     = run_s && cell_end_s && (cell_r == 6'd63);
    assign accept_s   = i_valid && ready_r;
    assign start_s    = run_s && (clk_cnt_r == CNT_ZERO) && (cell_r == 6'd0);
    assign load_nx_s  = (clk_cnt_nx == CNT_LAST) && (cell_nx == 6'd63);

    // Position counters: half-bit clock, cell, subframe channel, frame within block.
    always_comb begin
        clk_cnt_nx = clk_cnt_r;
        cell_nx    = cell_r;
        sub_nx     = sub_r;
        frame_nx   = frame_r;
        if (!run_s) begin
            clk_cnt_nx = CNT_ZERO;
            cell_nx    = 6'd0;
            sub_nx     = 1'b0;
            frame_nx   = 8'd0;
        end else if (cell_end_s) begin
            clk_cnt_nx = CNT_ZERO;
            cell_nx    = cell_r + 6'd1;
            if (cell_r == 6'd63) begin
                sub_nx = ~sub_r;
                if (sub_r) begin
                    frame_nx = (frame_r == 8'd191) ? 8'd0 : frame_r + 8'd1;
                end else begin
                    frame_nx = frame_r;
                end
            end else begin
                sub_nx = sub_r;
            end
        end else begin
            clk_cnt_nx = clk_cnt_r + CNT_ONE;
        end
    end

    // Holding register occupancy and the channel the next accepted payload will land in.
    always_comb begin
        ready_nx = ready_r;
        chan_nx  = 1'b0;
        if (accept_s) begin
            ready_nx = 1'b0;
        end else if (load_s) begin
            ready_nx = 1'b1;
        end else begin
            ready_nx = ready_r;
        end
        // An accept on the load cycle skips the subframe that just got the underrun payload.
        if (ready_nx) begin
            chan_nx = load_nx_s ? sub_nx : ~sub_nx;
        end else begin
            chan_nx = sub_nx;
        end
    end

    // Preamble selection and next line level at the first clock of each cell.
    always_comb begin
        pre_s   = PRE_W;
        line_nx = o_spdif_r;
        case ({sub_r, (frame_r == 8'd0)})
            2'b01:   pre_s = PRE_B;
            2'b00:   pre_s = PRE_M;
            default: pre_s = PRE_W;
        endcase
        if (!run_s) begin
            line_nx = 1'b0;
        end else if (clk_cnt_r == CNT_ZERO) begin
            if (cell_r < 6'd8) begin
                line_nx = pre_s[3'd7 - cell_r[2:0]] ^ ((cell_r == 6'd0) ? o_spdif_r : lvl_r);
            end else if (!cell_r[0]) begin
                line_nx = ~o_spdif_r;
            end else begin
                line_nx = o_spdif_r ^ sreg_r[cell_r[5:1]];
            end
        end else begin
            line_nx = o_spdif_r;
        end
    end

    // Counter, handshake and holding register state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_cnt_r  <= CNT_ZERO;
            cell_r     <= 6'd0;
            sub_r      <= 1'b0;
            frame_r    <= 8'd0;
            ready_r    <= 1'b1;
            o_chan_b_r <= 1'b0;
            hold_r     <= 27'd0;
        end else begin
            clk_cnt_r  <= clk_cnt_nx;
            cell_r     <= cell_nx;
            sub_r      <= sub_nx;
            frame_r    <= frame_nx;
            ready_r    <= ready_nx;
            o_chan_b_r <= chan_nx;
            if (accept_s) begin
                hold_r <= {i_c, i_u, i_v, i_data};
            end else begin
                hold_r <= hold_r;
            end
        end
    end

    // Subframe word load at the last clock of cell 63, with underrun substitution.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sreg_r  <= build_word(UNDERRUN_PL);
            uflag_r <= 1'b0;
        end else if (!run_s) begin
            sreg_r  <= build_word(UNDERRUN_PL);
            uflag_r <= 1'b0;
        end else if (load_s) begin
            sreg_r  <= build_word(ready_r ? UNDERRUN_PL : hold_r);
            uflag_r <= ready_r;
        end else begin
            sreg_r  <= sreg_r;
            uflag_r <= uflag_r;
        end
    end

    // Registered line and status pulses; lvl_r keeps the level that ended the previous subframe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lvl_r           <= 1'b0;
            o_spdif_r       <= 1'b0;
            o_block_start_r <= 1'b0;
            o_underrun_r    <= 1'b0;
        end else begin
            lvl_r           <= start_s ? o_spdif_r : (run_s ? lvl_r : 1'b0);
            o_spdif_r       <= line_nx;
            o_block_start_r <= start_s && !sub_r && (frame_r == 8'd0);
            o_underrun_r    <= start_s && uflag_r;
        end
    end

    assign o_ready       = ready_r;
    assign o_chan_b      = o_chan_b_r;
    assign o_spdif       = o_spdif_r;
    assign o_block_start = o_block_start_r;
    assign o_underrun    = o_underrun_r;

endmodule

// File: tb/tb_spdif_bmc_tx.sv
// Randomized scoreboard bench for spdif_bmc_tx: decodes the BMC line per subframe and compares with queued payloads.
module tb_spdif_bmc_tx;
    localparam int H   = 2;
    localparam int L   = 64 * H;
    localparam int BLK = 384 * L;
    localparam logic [7:0] PB = 8'b1110_1000;
    localparam logic [7:0] PM = 8'b1110_0010;
    localparam logic [7:0] PW = 8'b1110_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic [23:0] data = 24'd0;
    logic        v = 1'b0, u = 1'b0, c = 1'b0, valid = 1'b0;
    logic        o_ready, o_chan_b, o_spdif, o_block_start, o_underrun;

    always #5 clk = ~clk;

    spdif_bmc_tx #(.HALF_BIT_CLKS(H)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
`ifdef SPDIF_TX_ENABLE_EN
        .i_ena(ena),
`endif
        .i_data(data),
        .i_v(v),
        .i_u(u),
        .i_c(c),
        .i_valid(valid),
        .o_ready(o_ready),
        .o_chan_b(o_chan_b),
        .o_spdif(o_spdif),
        .o_block_start(o_block_start),
        .o_underrun(o_underrun)
    );

    typedef struct {
        int          idx;
        logic [26:0] pl;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pos;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Positions counted from reset release: state index of the current clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pos <= 0;
        else        pos <= pos + 1;
    end

    logic        cells [64];
    logic        last_lvl, prev_end;
    int          run_len;
    bit          run_ok;
    int          q, cl, ck, s, d, eb;
    bit          full, has_pl;
    logic [7:0]  pre, pat;
    logic [27:0] bits;
    logic [26:0] pl;

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            run_ok = 0; run_len = 0; last_lvl = 1'b0; prev_end = 1'b0;
        end else begin
            full = (sbq.size() > 0) && (pos <= sbq[$].idx * L - 1);
            chk("ready", o_ready, !full);
            if (valid && o_ready) begin
                d = (pos % L == L - 1) ? pos / L + 2 : pos / L + 1;
                chk("chan_b", o_chan_b, d % 2);
                sbq.push_back('{idx: d, pl: {c, u, v, data}});
            end
            if (pos > 0) begin
                q  = pos - 1;
                cl = (q / H) % 64;
                ck = q % H;
                s  = q / L;
                has_pl = (sbq.size() > 0) && (sbq[0].idx == s);
                chk("block_start", o_block_start, (q % BLK) == 0);
                chk("underrun", o_underrun, (q % L == 0) && (s >= 1) && !has_pl);
                if (ck == 0) cells[cl] = o_spdif;
                else         chk("cell_hold", o_spdif, cells[cl]);
                if (o_spdif !== last_lvl) begin
                    if (run_ok) begin
                        n_cmp++;
                        if (!(run_len == H || run_len == 2 * H || run_len == 3 * H)) begin
                            n_bad++;
                            $display("FAIL edge_gap: got %0d clocks, required %0d/%0d/%0d", run_len, H, 2 * H, 3 * H);
                        end
                    end
                    run_ok = 1; run_len = 1; last_lvl = o_spdif;
                end else begin
                    run_len++;
                end
                if (cl == 63 && ck == H - 1) begin
                    pat = (s % 384 == 0) ? PB : ((s % 2 == 0) ? PM : PW);
                    for (int k = 0; k < 8; k++) pre[7 - k] = cells[k];
                    chk("preamble", pre, pat ^ {8{prev_end}});
                    eb = 0;
                    for (int sl = 4; sl < 32; sl++) begin
                        bits[sl - 4] = cells[2 * sl] ^ cells[2 * sl + 1];
                        if (cells[2 * sl] === cells[2 * sl - 1]) eb++;
                    end
                    chk("slot_edge", eb, 0);
                    if (has_pl) pl = sbq.pop_front().pl;
                    else        pl = 27'h100_0000;
                    chk("payload", bits[26:0], pl);
                    chk("parity", bits[27], ^pl);
                    prev_end = cells[63];
                end
            end
        end
    end

    bit idle;

    task automatic drive_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 299) == 0) idle = ~idle;
            valid = !idle && ($urandom_range(0, 7) != 0);
            data  = 24'($urandom);
            v = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        idle = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spdif", o_spdif, 1'b0);
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_chan_b", o_chan_b, 1'b0);
        chk("rst_block_start", o_block_start, 1'b0);
        chk("rst_underrun", o_underrun, 1'b0);
        #2 rst_n = 1'b1;
        repeat (3 * L) @(posedge clk);
        drive_random(BLK + 4 * L);

        // Fill the holding register, then reset mid-subframe.
        @(posedge clk); #1;
        valid = 1'b1;
        for (int i = 0; i < 4 * L && o_ready; i++) @(negedge clk);
        chk("hold_fill", o_ready, 1'b0);
        repeat (L / 4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_spdif", o_spdif, 1'b0);
        chk("mid_rst_ready", o_ready, 1'b1);
        valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2 * L) @(posedge clk);
        drive_random(4 * L);
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (3 * L) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
